// File: rtl/uart_pkg.sv
// Shared encodings for the debug-UART transmitter: FSM state codes and frame geometry.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

endpackage

// File: rtl/sync_fifo.sv
// Small circular-buffer FIFO with a separate occupancy counter and fall-through head read.
// A push into a full FIFO is discarded, never overwriting the oldest entry.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  push_ok, pop_ok;

    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: pointers and count define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == (DEPTH_LOG2+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 debug-UART transmitter: byte FIFO drained back-to-back into a serializer.
// Optional sticky drop flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 14_000_000,
    parameter int BIT_RATE   = 1_000_000,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [7:0]            wr_data,
    input  logic                  clr_ovf,
    output logic                  uart_txd,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  overflow
);

    localparam int CPB   = CLK_HZ / BIT_RATE;
    localparam int DIV_W = (CPB > 1) ? $clog2(CPB) : 1;

    generate
        if (CPB < 2) begin : g_bad_cpb
            $error("uart_tx_fifo: CLK_HZ/BIT_RATE must be at least 2");
        end
        if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 4) begin : g_bad_depth
            $error("uart_tx_fifo: DEPTH_LOG2 must be within 1..4");
        end
    endgenerate

    state_e         state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           txd_q, txd_d;
    logic           pop, bit_end;
    logic           fifo_full, fifo_empty;
    logic [7:0]     fifo_rd_data;

    sync_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (wr_en),
        .pop     (pop),
        .wr_data (wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (count)
    );

    // txd_d is the line level for the cycle after this edge, so the pin is a plain flop.
    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        txd_d     = txd_q;
        pop       = 1'b0;
        bit_end   = (div_q == DIV_W'(CPB - 1));
        div_d     = bit_end ? '0 : div_q + DIV_W'(1);
        case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                div_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    shift_d = fifo_rd_data;
                    state_d = START;
                    txd_d   = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                    txd_d     = shift_q[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        txd_d   = 1'b1;
                    end else begin
                        shift_d   = shift_q >> 1;
                        bit_idx_d = bit_idx_q + 3'd1;
                        txd_d     = shift_q[1];
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        shift_d = fifo_rd_data;
                        state_d = START;
                        txd_d   = 1'b0;
                    end else begin
                        state_d = IDLE;
                        txd_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                txd_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            txd_q     <= txd_d;
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // A drop on the same edge as a clear must still be reported.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && fifo_full) ovf_d = 1'b1;
        else if (clr_ovf)       ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) ovf_q <= 1'b0;
        else        ovf_q <= ovf_d;
    end

    assign overflow = ovf_q;
`else
    logic unused_clr_ovf;
    assign unused_clr_ovf = clr_ovf;
    assign overflow       = 1'b0;
`endif

    assign uart_txd = txd_q;
    assign full     = fifo_full;
    assign empty    = fifo_empty;
    assign busy     = !fifo_empty || (state_q != IDLE);

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Buffered debug-UART transmitter sitting directly downstream of the top-level bus decode: CPU writes to the debug UART address are pushed into a small byte FIFO, which is drained into a built-in 8N1 serializer driving the debug TX pin. Firmware can queue several bytes without polling status per byte. The status register now reports `busy` (FIFO non-empty or frame in flight) instead of the bare shifter busy bit.

## Interface
- `CLK_HZ`, 14_000_000, system clock frequency.
- `BIT_RATE`, 1_000_000, UART bit rate; `CPB = CLK_HZ/BIT_RATE` (integer, ≥2, elaboration error otherwise).
- `DEPTH_LOG2`, 2, FIFO depth = 2^DEPTH_LOG2 entries (range 1..4).

- `clk` in 1: single clock, all logic on posedge.
- `rst_n` in 1: reset, synchronous, active-low.
- `wr_en` in 1: push request (bus write decoded to debug UART, one-cycle pulse).
- `wr_data` in 8: byte to push.
- `clr_ovf` in 1: clears `overflow` (only functional with macro).
- `uart_txd` out 1: serial output, idle high.
- `full` out 1: FIFO count == depth.
- `empty` out 1: FIFO count == 0.
- `count` out DEPTH_LOG2+1: FIFO occupancy.
- `busy` out 1: `!empty || state != IDLE`.
- `overflow` out 1: sticky dropped-write flag.

## Operation
- Reset values: `uart_txd`=1, `full`=0, `empty`=1, `count`=0, `busy`=0, `overflow`=0, state IDLE, divider 0, FIFO pointers 0.
- FIFO: circular buffer, wr/rd pointers DEPTH_LOG2 bits, wrap modulo depth; `count` separate register.
- Push: `wr_en && !full` writes `wr_data`, count+1. `wr_en && full` drops the byte (never overwrites), even if a pop occurs the same cycle.
- Simultaneous push (non-full) and pop: count unchanged, both pointers advance.
- FSM: IDLE, START, DATA, STOP.
  - IDLE: `uart_txd`=1; if `!empty` pop head into shift register, go START, divider=0.
  - START: `uart_txd`=0 for CPB cycles, then DATA, bit index 0.
  - DATA: `uart_txd`=shift[0], LSB first; each CPB cycles shift right, index+1; after 8th bit go STOP.
  - STOP: `uart_txd`=1 for CPB cycles; at end, if `!empty` pop and go START directly (no idle gap), else IDLE.
- Divider counts 0..CPB-1; bit boundary when divider == CPB-1.
- Output registered: `uart_txd` a flop, glitch-free.
- `rst_n` low mid-frame: FIFO flushed, frame aborted, `uart_txd`=1 after that edge.

## Timing
- Push on edge N into empty FIFO while IDLE: count=1 after N; pop at edge N+1; `uart_txd` low from N+1 for CPB cycles.
- Frame length exactly 10×CPB cycles; back-to-back frames contiguous.
- `full`/`empty`/`count`/`busy` reflect registered state after each edge (combinational from registers, no extra latency).
- `busy` drops the cycle after the final stop-bit edge when FIFO empty.

## Configuration
- `UART_TX_FIFO_OVF_EN` defined: `overflow` set on the edge of any dropped write, held until `clr_ovf` high on an edge (clr wins if both same cycle? no — set wins, so a drop coincident with clear is not lost).
- Undefined: `overflow` tied 0, `clr_ovf` ignored; no flag register synthesized.

## Structure
- Package `uart_pkg`: state encoding constants (IDLE=0, START=1, DATA=2, STOP=3), `FRAME_BITS`=10, `DATA_BITS`=8.
- Sub-module `sync_fifo` (parameters WIDTH, DEPTH_LOG2; push/pop/full/empty/count); top holds FSM, divider, shifter, overflow flag.

## Test plan
- Single byte 0x55, CPB=14: push at cycle 0 -> txd low cycles 1–14, then bits 1,0,1,0,1,0,1,0 each 14 cycles, stop high 14 cycles; `busy` low at cycle 141.
- Burst 4 pushes 0x01..0x04 on consecutive cycles (depth 4): count peaks 3 (first popped), four contiguous frames, total 560 cycles, no idle gap.
- Five pushes while shifter busy and FIFO full: fifth byte dropped, `overflow`=1 (macro on) / 0 (macro off); transmitted sequence excludes it.
- Push and pop same cycle with count=2: count stays 2, order preserved.
- Reset asserted mid-DATA of byte 0xA3: txd=1, count=0, `busy`=0 next cycle; post-reset push 0x3C transmits cleanly.
- `clr_ovf` pulse with flag set and no drop -> `overflow`=0; coincident drop -> stays 1.
